seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle successor to the team's 6-bit registered comparator.
- Compares two WIDTH-bit operands, signed or unsigned, MSB-first, CHUNK bits per clock.
- Terminates early on the first differing chunk.
- Uses a valid/ready start handshake and a one-cycle done pulse. This allows wide operands without a long combinational compare path.

Parameters:
- WIDTH, 16: operand width in bits; must be an integer multiple of CHUNK, and at least 2.
- CHUNK, 4: bits compared per clock cycle. NCH = WIDTH/CHUNK is the maximum number of compare cycles.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-low reset.
- START  input  1  request valid; accepted on a rising edge where START=1 and READY=1.
- A  input  WIDTH  operand A; sampled only at acceptance.
- B  input  WIDTH  operand B; sampled only at acceptance.
- S  input  1  mode, sampled at acceptance: 1 = two's-complement signed, 0 = unsigned.
- READY  output  1  block idle; can accept START.
- DONE  output  1  one-cycle pulse; result valid and newly updated.
- regE  output  1  A == B.
- regL  output  1  A < B.
- regG  output  1  A > B.
- CYC  output  clog2(NCH)+1  number of compare cycles the last operation used (1..NCH).

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, READY=1, DONE=0, regE=regL=regG=0, CYC=0, and internal operand/index registers cleared. Reset mid-operation abandons the compare with no DONE pulse.
- States:
  - IDLE: READY=1.
  - RUN: READY=0.
- IDLE -> RUN on acceptance edge: latch A, B, S; chunk index i=NCH-1; cycle count=1.
- RUN, each cycle: compare chunk i (bits [i*CHUNK+CHUNK-1 : i*CHUNK]) of the latched operands combinationally. On the next edge:
  - Chunks differ: regG=(chunkA>chunkB unsigned), regL=!regG, regE=0, DONE=1, READY=1, -> IDLE.
  - Chunks equal and i==0: regE=1, regL=regG=0, DONE=1, READY=1, -> IDLE.
  - Chunks equal and i>0: i=i-1, count+1, stay RUN.
- Signed rule applies only when S=1 and i==NCH-1. If A[WIDTH-1] != B[WIDTH-1], the decision is regG=B[WIDTH-1], regL=A[WIDTH-1] in that cycle. Otherwise use the plain unsigned chunk compare; this is valid for equal signs in two's complement.
- Latency: DONE rises k edges after the acceptance edge, where k = index of the first differing chunk counted from the MSB (1..NCH). Equal operands always take NCH. CYC=k is registered with DONE.
- Outputs regE/regL/regG/CYC hold their last values between operations. They update only on a DONE edge. After the first completion, exactly one of regE/regL/regG is 1.
- DONE is high exactly one cycle per accepted operation.
- START while READY=0 is ignored, not queued.
- Back-to-back: START=1 in the cycle DONE=1 (READY=1) is accepted on the next edge. Throughput is one operation per k+1 cycles.
- A/B/S changes after acceptance have no effect on the running compare.

Test Plan (WIDTH=16, CHUNK=4, NCH=4):
1. Reset: hold RST=0, pulse START -> READY=1, DONE=0, regE/L/G=0, CYC=0; no operation starts.
2. Unsigned early exit: A=16'h8000, B=16'h7FFF, S=0, START 1 cycle -> DONE 1 edge after acceptance; regG=1, regL=0, regE=0, CYC=1.
3. Signed sign-differ: same A/B with S=1 -> regL=1, regG=0, CYC=1. Also A=16'hFFFE, B=16'hFFFC, S=1 -> regG=1, CYC=4.
4. Equality, full latency: A=B=16'h1234, S=0 -> DONE exactly 4 edges after acceptance; regE=1, CYC=4. Change A to 16'h0000 during RUN -> result unchanged.
5. Handshake: START held high continuously with fresh operands -> a new acceptance every k+1 cycles. START pulsed while READY=0 is ignored. Hold START low after completion -> outputs hold and DONE stays 0.
6. Reset mid-run: A=B=16'hABCD, assert RST=0 two cycles after acceptance -> no DONE pulse, outputs=0, READY=1. Then 500 random A/B/S operations are compared against a behavioural signed/unsigned model at each DONE, checking CYC against the expected first-differing-chunk index.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, and stops on the first differing chunk.
// Signed (two's complement) or unsigned mode is latched with the operands.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             START,
  input  logic [WIDTH-1:0]                 A,
  input  logic [WIDTH-1:0]                 B,
  input  logic                             S,
  output logic                             READY,
  output logic                             DONE,
  output logic                             regE,
  output logic                             regL,
  output logic                             regG,
  output logic [$clog2(WIDTH/CHUNK):0]     CYC
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW  = $clog2(NCH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  stateT            stateQ;
  stateT            stateNext;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             opS;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic             signSplit;
  logic             chunkDiff;
  logic             chunkGt;
  logic             accept;
  logic             finish;

  // Select the current chunk and decide it; the sign bits override on the top chunk in signed mode
  always_comb begin
    chunkA    = CHUNK'(opA >> (idx * CHUNK));
    chunkB    = CHUNK'(opB >> (idx * CHUNK));
    signSplit = opS && (idx == IW'(NCH - 1)) && (opA[WIDTH-1] != opB[WIDTH-1]);
    chunkDiff = chunkA != chunkB;
    chunkGt   = chunkA > chunkB;
    if (signSplit) begin
      chunkDiff = 1'b1;
      chunkGt   = opB[WIDTH-1];
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Next-state decode: accept in IDLE, finish on a differing chunk or the last chunk
  always_comb begin
    stateNext = stateQ;
    accept    = 1'b0;
    finish    = 1'b0;
    case (stateQ)
      IDLE: begin
        if (START) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (chunkDiff || (idx == IW'(0))) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand latch, chunk walk and registered result/handshake outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      opA   <= '0;
      opB   <= '0;
      opS   <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
      READY <= 1'b1;
      DONE  <= 1'b0;
      regE  <= 1'b0;
      regL  <= 1'b0;
      regG  <= 1'b0;
      CYC   <= '0;
    end else begin
      DONE  <= 1'b0;
      READY <= (stateNext == IDLE);
      if (accept) begin
        opA <= A;
        opB <= B;
        opS <= S;
        idx <= IW'(NCH - 1);
        cnt <= CW'(1);
      end else if (finish) begin
        DONE <= 1'b1;
        CYC  <= cnt;
        if (chunkDiff) begin
          regE <= 1'b0;
          regG <= chunkGt;
          regL <= !chunkGt;
        end else begin
          regE <= 1'b1;
          regG <= 1'b0;
          regL <= 1'b0;
        end
      end else if (stateQ == RUN) begin
        idx <= idx - IW'(1);
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed and randomised bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [15:0] A;
  logic [15:0] B;
  logic        S;
  logic        READY;
  logic        DONE;
  logic        regE;
  logic        regL;
  logic        regG;
  logic [2:0]  CYC;

  int nVec;
  int nFail;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  k;
    logic        e;
    logic        l;
    logic        g;
  } vecT;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .S(S),
    .READY(READY), .DONE(DONE), .regE(regE), .regL(regL), .regG(regG), .CYC(CYC)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one request through its acceptance edge, then drop START
  task automatic startOp(input logic [15:0] a, input logic [15:0] b, input logic s);
    START = 1'b1; A = a; B = b; S = s;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Count edges after acceptance until DONE is seen; 99 marks a timeout
  task automatic waitDone(output int edges);
    edges = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        edges = n;
        break;
      end
    end
  endtask

  // Reference result computed directly from the integer values
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic e, output logic l, output logic g, output int k);
    e = (a == b);
    if (s) begin
      g = $signed(a) > $signed(b);
      l = $signed(a) < $signed(b);
    end else begin
      g = a > b;
      l = a < b;
    end
    k = 0;
    if (s && (a[15] != b[15])) k = 1;
    for (int c = 3; c >= 0; c--) begin
      if ((k == 0) && (a[c*4 +: 4] != b[c*4 +: 4])) k = 4 - c;
    end
    if (k == 0) k = 4;
  endfunction

  task automatic test_reset();
    RST = 1'b0; START = 1'b1; A = 16'h1234; B = 16'h1234; S = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #1;
      nVec++;
      if ({READY, DONE, regE, regL, regG, CYC} !== 8'h80) begin
        nFail++;
        $display("FAIL reset_hold: got %b want %b", {READY, DONE, regE, regL, regG, CYC}, 8'h80);
      end
    end
    START = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== 8'h80) begin
      nFail++;
      $display("FAIL reset_release: got %b want %b", {READY, DONE, regE, regL, regG, CYC}, 8'h80);
    end
  endtask

  task automatic test_unsigned_early();
    int k;
    startOp(16'h8000, 16'h7FFF, 1'b0);
    nVec++;
    if (READY !== 1'b0) begin
      nFail++;
      $display("FAIL uns_busy: got READY=%b want 0", READY);
    end
    waitDone(k);
    nVec++;
    if (k != 1) begin
      nFail++;
      $display("FAIL uns_latency: got %0d want 1", k);
    end
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1}) begin
      nFail++;
      $display("FAIL uns_result: got %b want %b", {READY, DONE, regE, regL, regG, CYC},
               {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1});
    end
  endtask

  task automatic test_signed();
    int k;
    startOp(16'h8000, 16'h7FFF, 1'b1);
    waitDone(k);
    nVec++;
    if (k != 1) begin
      nFail++;
      $display("FAIL sgn_split_latency: got %0d want 1", k);
    end
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1}) begin
      nFail++;
      $display("FAIL sgn_split_result: got %b want %b", {READY, DONE, regE, regL, regG, CYC},
               {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1});
    end
    @(posedge CLK); #1;
    startOp(16'hFFFE, 16'hFFFC, 1'b1);
    waitDone(k);
    nVec++;
    if (k != 4) begin
      nFail++;
      $display("FAIL sgn_same_latency: got %0d want 4", k);
    end
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4}) begin
      nFail++;
      $display("FAIL sgn_same_result: got %b want %b", {READY, DONE, regE, regL, regG, CYC},
               {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4});
    end
  endtask

  task automatic test_equal();
    int k;
    @(posedge CLK); #1;
    startOp(16'h1234, 16'h1234, 1'b0);
    A = 16'h0000;
    waitDone(k);
    nVec++;
    if (k != 4) begin
      nFail++;
      $display("FAIL eq_latency: got %0d want 4", k);
    end
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4}) begin
      nFail++;
      $display("FAIL eq_result: got %b want %b", {READY, DONE, regE, regL, regG, CYC},
               {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4});
    end
  endtask

  task automatic test_busy_ignore();
    int k;
    @(posedge CLK); #1;
    startOp(16'h1234, 16'h1234, 1'b0);
    START = 1'b1; A = 16'h0000; B = 16'hFFFF;
    @(posedge CLK); #1;
    START = 1'b0;
    nVec++;
    if ({READY, DONE} !== 2'b00) begin
      nFail++;
      $display("FAIL busy_state: got %b want 00", {READY, DONE});
    end
    waitDone(k);
    nVec++;
    if (k != 3) begin
      nFail++;
      $display("FAIL busy_latency: got %0d want 3 more edges", k);
    end
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4}) begin
      nFail++;
      $display("FAIL busy_result: got %b want %b", {READY, DONE, regE, regL, regG, CYC},
               {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4});
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge CLK); #1;
      nVec++;
      if ({READY, DONE, regE, regL, regG, CYC} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4}) begin
        nFail++;
        $display("FAIL idle_hold: got %b want %b", {READY, DONE, regE, regL, regG, CYC},
                 {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4});
      end
    end
  endtask

  task automatic test_back_to_back();
    vecT ops [5];
    int k;
    ops[0] = {16'h8000, 16'h7FFF, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
    ops[1] = {16'h1234, 16'h1235, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
    ops[2] = {16'h1200, 16'h1300, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
    ops[3] = {16'hFFFF, 16'h0001, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
    ops[4] = {16'h5555, 16'h5555, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    START = 1'b1; A = ops[0].a; B = ops[0].b; S = ops[0].s;
    for (int j = 0; j < 5; j++) begin
      @(posedge CLK); #1;
      nVec++;
      if (READY !== 1'b0) begin
        nFail++;
        $display("FAIL b2b_accept[%0d]: got READY=%b want 0", j, READY);
      end
      waitDone(k);
      nVec++;
      if (k != int'(ops[j].k)) begin
        nFail++;
        $display("FAIL b2b_latency[%0d]: got %0d want %0d", j, k, ops[j].k);
      end
      nVec++;
      if ({READY, DONE, regE, regL, regG, CYC} !== {1'b1, 1'b1, ops[j].e, ops[j].l, ops[j].g, ops[j].k}) begin
        nFail++;
        $display("FAIL b2b_result[%0d]: got %b want %b", j, {READY, DONE, regE, regL, regG, CYC},
                 {1'b1, 1'b1, ops[j].e, ops[j].l, ops[j].g, ops[j].k});
      end
      if (j < 4) begin
        A = ops[j+1].a; B = ops[j+1].b; S = ops[j+1].s;
      end else begin
        START = 1'b0;
      end
    end
    @(posedge CLK); #1;
    nVec++;
    if ({READY, DONE} !== 2'b10) begin
      nFail++;
      $display("FAIL b2b_idle: got %b want 10", {READY, DONE});
    end
  endtask

  task automatic test_reset_mid_run();
    startOp(16'hABCD, 16'hABCD, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== 8'h80) begin
      nFail++;
      $display("FAIL midrst_clear: got %b want %b", {READY, DONE, regE, regL, regG, CYC}, 8'h80);
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #1;
      nVec++;
      if ({READY, DONE, regE, regL, regG, CYC} !== 8'h80) begin
        nFail++;
        $display("FAIL midrst_hold: got %b want %b", {READY, DONE, regE, regL, regG, CYC}, 8'h80);
      end
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    nVec++;
    if ({READY, DONE, regE, regL, regG, CYC} !== 8'h80) begin
      nFail++;
      $display("FAIL midrst_after: got %b want %b", {READY, DONE, regE, regL, regG, CYC}, 8'h80);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        e;
    logic        l;
    logic        g;
    int          kExp;
    int          k;
    int          sel;
    for (int n = 0; n < 500; n++) begin
      a   = 16'($urandom);
      s   = 1'($urandom);
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       b = a;
        1:       b = a ^ 16'($urandom_range(1, 15));
        2:       b = a ^ 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      model(a, b, s, e, l, g, kExp);
      startOp(a, b, s);
      waitDone(k);
      nVec++;
      if (k != kExp) begin
        nFail++;
        $display("FAIL rnd_latency[%0d] a=%h b=%h s=%b: got %0d want %0d", n, a, b, s, k, kExp);
      end
      nVec++;
      if ({regE, regL, regG, CYC} !== {e, l, g, 3'(kExp)}) begin
        nFail++;
        $display("FAIL rnd_result[%0d] a=%h b=%h s=%b: got %b want %b", n, a, b, s,
                 {regE, regL, regG, CYC}, {e, l, g, 3'(kExp)});
      end
      @(posedge CLK); #1;
    end
  endtask

  // Scenario sequence and summary
  initial begin
    nVec  = 0;
    nFail = 0;
    RST   = 1'b0;
    START = 1'b0;
    A     = '0;
    B     = '0;
    S     = 1'b0;
    test_reset();
    test_unsigned_early();
    test_signed();
    test_equal();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
